// File: rtl/mem_pkg.sv
// Shared encodings for the load/store front end: access sizes, FSM states
// and the alignment check used both at request time and by the bench.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    WRITE = ST_WRITE,
    RESP  = ST_RESP
  } state_t;

  // True for size 11, a halfword on an odd address, or a word off a 4-byte boundary.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: is_bad_access = 1'b0;
      SIZE_HALF: is_bad_access = addr_lo[0];
      SIZE_WORD: is_bad_access = (addr_lo != 2'b00);
      default:   is_bad_access = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: merges store data into a RAM word and
// extracts/extends a load value from a RAM word. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_store_word,
  output logic [31:0] o_load_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lanes, then merge (store) or extend (load) by size.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can infer a latch.
    o_store_word = i_word;
    o_load_value = '0;
    w_byte       = i_word[{i_addr, 3'b000} +: 8];
    w_half       = i_word[{i_addr[1], 4'b0000} +: 16];
    case (i_size)
      SIZE_BYTE: begin
        o_store_word[{i_addr, 3'b000} +: 8] = i_wdata[7:0];
        o_load_value = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      SIZE_HALF: begin
        o_store_word[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
        o_load_value = {{16{i_signed & w_half[15]}}, w_half};
      end
      SIZE_WORD: begin
        o_store_word = i_wdata;
        o_load_value = i_word;
      end
      default: begin
        o_store_word = i_word;
        o_load_value = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-addressed data RAM. Unpipelined:
// IDLE -> READ -> (WRITE) -> RESP, with sub-word stores done as read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  ram_store,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_err;
  logic [31:0]           r_word;

  logic                  w_accept;
  logic                  w_req_err;
  logic [ADDR_WIDTH-1:0] w_word_addr;
  logic [31:0]           w_store_word;
  logic [31:0]           w_load_value;

  assign w_accept    = req_valid && req_ready;
  assign w_req_err   = is_bad_access(req_size, req_addr[1:0]);
  assign w_word_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};

  mem_lane_align u_align (
    .i_word       (r_word),
    .i_wdata      (r_wdata),
    .i_addr       (r_addr[1:0]),
    .i_size       (r_size),
    .i_signed     (r_signed),
    .o_store_word (w_store_word),
    .o_load_value (w_load_value)
  );

  // State register; reset returns to IDLE immediately, which also drops ram_store.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values regardless of statement order.
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Request capture on handshake and RAM word capture in READ.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_word   <= '0;
    end else begin
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_req_err;
      end
      if (r_state == READ) r_word <= ram_rdata;
    end
  end

  // Next-state and all outputs; unqualified data outputs are driven to 0.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_error = 1'b0;
    ram_store  = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_req_err ? RESP : READ;
      end
      READ: begin
        ram_addr = w_word_addr;
        w_next   = r_write ? WRITE : RESP;
      end
      WRITE: begin
        ram_addr  = w_word_addr;
        ram_store = 1'b1;
        ram_wdata = w_store_word;
        w_next    = RESP;
      end
      RESP: begin
        ram_addr   = w_word_addr;
        resp_valid = 1'b1;
        resp_error = r_err;
        if (!r_write && !r_err) resp_rdata = w_load_value;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front end sitting directly upstream of the word-addressed data RAM. It accepts byte, halfword and word load/store requests from the CPU memory stage over a valid/ready handshake. Sub-word stores are performed as read-modify-write on the RAM's 32-bit word. Loads return a zero- or sign-extended result, and misaligned or illegal-size requests are flagged as errors.

Parameters:
ADDR_WIDTH, 10, byte-address width; must match the RAM address port.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request; high only in IDLE
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data; the low bits are used for sub-word stores
resp_valid  output  1  one-cycle pulse when the request completes
resp_rdata  output  32  load result; 0 for stores and errors
resp_error  output  1  qualified by resp_valid; misaligned access or size 11
ram_store  output  1  RAM write enable
ram_addr  output  ADDR_WIDTH  RAM byte address, word-aligned (low 2 bits 0)
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM combinational read data for ram_addr

Behaviour:
- Reset state (asynchronous): state = IDLE.
- Output values in reset: req_ready = 1, resp_valid = 0, resp_error = 0, resp_rdata = 0, ram_store = 0, ram_addr = 0, ram_wdata = 0.
- All internal latches clear to 0.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - A handshake occurs when req_valid and req_ready are both high.
  - On handshake, latch write, size, signed, addr and wdata.
  - Error condition: size 11, or half with addr[0] = 1, or word with addr[1:0] != 0. On error, go to RESP with the error flag set and do not touch the RAM.
  - Otherwise go to READ.
- READ:
  - ram_addr = {latched addr[ADDR_WIDTH-1:2], 2'b00}.
  - Capture ram_rdata into word_q.
  - Next state is WRITE for a store, RESP for a load.
- WRITE:
  - ram_store = 1 for exactly this cycle.
  - ram_wdata = word_q with the addressed lane replaced (little-endian):
    - byte: bits [8*a[1:0]+7 : 8*a[1:0]] = wdata[7:0]
    - half: bits [16*a[1]+15 : 16*a[1]] = wdata[15:0]
    - word: wdata
  - Next state is RESP.
- RESP:
  - resp_valid = 1 for one cycle, then return to IDLE.
  - Loads: resp_rdata = the extracted lane of word_q, sign-extended if signed, else zero-extended.
  - Stores and errors: resp_rdata = 0.
  - resp_error = the latched error flag.
- Latency, counted in cycles after the accepting edge:
  - load: resp_valid in cycle 2
  - store: ram write at the end of cycle 2, resp_valid in cycle 3
  - error: resp_valid in cycle 1
- ram_addr holds the latched word address from READ through RESP.
- ram_store is 0 in every state except WRITE.
- The unit is not pipelined: req_ready is low in READ, WRITE and RESP, and a request held valid is accepted only on the cycle the unit is back in IDLE.
- Reset asserted mid-operation: return to IDLE immediately and drop ram_store combinationally. A store interrupted in WRITE before the clock edge must not modify the RAM, and no resp_valid is produced.
- resp_rdata, resp_error and ram_wdata are don't-care-free: they are driven to 0 when not qualified.

Decomposition:
- Shared package mem_pkg:
  - size encodings SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10
  - state encoding localparams for IDLE, READ, WRITE, RESP
- One natural combinational sub-module, mem_lane_align:
  - inputs: word, wdata, addr[1:0], size, signed
  - outputs: the merged store word and the extended load value
  - it is reused by the verification model.

Test Plan:
- RAM zeroed; store word at 0x004 with 0xDEADBEEF -> ram_store high only in cycle 2, ram_addr = 0x004, ram_wdata = 0xDEADBEEF; resp_valid in cycle 3 with resp_error = 0 and resp_rdata = 0.
- Then store byte at 0x005 with 0x000000AA -> ram_wdata = 0xDEADAAEF. Then store half at 0x006 with 0x00001234 -> ram_wdata = 0x1234AAEF.
- Loads from word 0x1234AAEF:
  - signed byte at 0x005 -> 0xFFFFFFAA
  - unsigned byte at 0x005 -> 0x000000AA
  - signed half at 0x004 -> 0xFFFFAAEF
  - word at 0x004 -> 0x1234AAEF
  - each with resp_valid in cycle 2
- Load word at 0x006, store half at 0x003, and any request with size 11 -> resp_valid in cycle 1 with resp_error = 1 and resp_rdata = 0. ram_store never asserts.
- Assert reset asynchronously during WRITE of a store word 0x11111111 to 0x008 -> ram_store falls the same cycle, no resp_valid; a following load word at 0x008 returns 0x00000000.
- req_valid held high across two back-to-back loads -> req_ready = 0 in READ and RESP. The second request is accepted in the IDLE cycle after the first resp_valid, giving exactly 3 cycles between accepts.
